reset_sequencer: RTL and testbench

Parametrised reset generator that synchronises the board-level asynchronous reset into the `clk` domain and holds every downstream reset for a programmable minimum time. It then releases `NUM_OUT` reset outputs one at a time, in a fixed order, so the pipeline stages come up back-to-front. A synchronous software reset request re-runs the whole sequence without touching `rst_async`. It sits at the top of the design, between the board reset and the per-stage reset inputs.

---
 rtl/reset_sequencer.sv | 138 +++++++++++++
 tb/tb_reset_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises the board reset, holds all stage resets,
// then releases them one by one so the pipeline comes up back-to-front.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_OUT     = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               rst_async,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_cnt,   w_cnt;
  logic [IW-1:0]      r_idx,   w_idx;
  logic [NUM_OUT-1:0] r_out,   w_out;
  logic               r_done,  w_done;
  logic               w_expire;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign w_rst_sync = r_sync[SYNC_STAGES-1];
  assign w_expire   = (r_cnt == C_ONE);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_out   = r_out;
    w_done  = r_done;
    if (sw_rst_req && !w_rst_sync) begin
      w_state = ST_HOLD;
      w_cnt   = C_HOLD;
      w_idx   = '0;
      w_out   = '1;
      w_done  = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          // counter stays frozen until the synchroniser lets go
          if (!w_rst_sync) begin
            if (w_expire) begin
              w_out[0] = 1'b0;
              w_cnt    = C_GAP;
              w_idx    = I_ONE;
              if (NUM_OUT == 1) begin
                w_state = ST_DONE;
                w_done  = 1'b1;
              end else begin
                w_state = ST_RELEASE;
              end
            end else begin
              w_cnt = r_cnt - C_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (w_expire) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (IW'(i) == r_idx) begin
                w_out[i] = 1'b0;
              end
            end
            w_idx = r_idx + I_ONE;
            w_cnt = C_GAP;
            if (r_idx == I_LAST) begin
              w_state = ST_DONE;
              w_out   = '0;
              w_done  = 1'b1;
            end
          end else begin
            w_cnt = r_cnt - C_ONE;
          end
        end
        ST_DONE: begin
          w_out  = '0;
          w_done = 1'b1;
        end
        default: begin
          w_state = ST_HOLD;
          w_cnt   = C_HOLD;
          w_idx   = '0;
          w_out   = '1;
          w_done  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state <= ST_HOLD;
      r_cnt   <= C_HOLD;
      r_idx   <= '0;
      r_out   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_out   <= w_out;
      r_done  <= w_done;
    end
  end

  assign rst_out  = r_out;
  assign rst_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of the default build and two
// parameter corners, all driven from the same reset inputs.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_async;
  logic       sw_rst_req;
  logic [3:0] def_out;
  logic       def_done;
  logic [0:0] a_out;
  logic       a_done;
  logic [7:0] b_out;
  logic       b_done;
  logic [15:0] act;

  int n_checks;
  int n_fail;
  int edge_n;

  reset_sequencer u_def (
    .clk        (clk),
    .rst_async  (rst_async),
    .sw_rst_req (sw_rst_req),
    .rst_out    (def_out),
    .rst_done   (def_done)
  );

  reset_sequencer #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .NUM_OUT     (1)
  ) u_a (
    .clk        (clk),
    .rst_async  (rst_async),
    .sw_rst_req (sw_rst_req),
    .rst_out    (a_out),
    .rst_done   (a_done)
  );

  reset_sequencer #(
    .GAP_CYCLES (1),
    .NUM_OUT    (8)
  ) u_b (
    .clk        (clk),
    .rst_async  (rst_async),
    .sw_rst_req (sw_rst_req),
    .rst_out    (b_out),
    .rst_done   (b_done)
  );

  assign act = {def_done, def_out, a_done, a_out, b_done, b_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] ALL_RST = {5'h0F, 2'b01, 9'h0FF};

  // {done, out} for the default build, bit 0 falling at edge e0
  function automatic logic [4:0] exp_def(int n, int e0);
    if (n < e0)           return 5'h0F;
    else if (n < e0 + 8)  return 5'h0E;
    else if (n < e0 + 16) return 5'h0C;
    else if (n < e0 + 24) return 5'h08;
    else                  return 5'h10;
  endfunction

  function automatic logic [1:0] exp_a(int n, int e0);
    return (n < e0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [8:0] exp_b(int n, int e0);
    logic [7:0] ff;
    ff = 8'hFF;
    if (n < e0)          return {1'b0, ff};
    else if (n >= e0 + 7) return 9'h100;
    else                 return {1'b0, ff << (n - e0 + 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    rst_async  = 1'b0;
    sw_rst_req = 1'b0;
    #2;
    rst_async = 1'b1;
    #1;
    n_checks++;
    if (act !== ALL_RST) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act, ALL_RST);
    end
  endtask

  task automatic test_power_up(input logic sw_dur);
    logic [15:0] exp;
    @(negedge clk);
    rst_async = 1'b1;
    #1;
    n_checks++;
    if (act !== ALL_RST) begin
      n_fail++;
      $display("FAIL pu_assert: got %h expected %h", act, ALL_RST);
    end
    repeat (3) @(negedge clk);
    rst_async  = 1'b0;
    sw_rst_req = sw_dur;
    edge_n     = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (edge_n == 2) sw_rst_req = 1'b0;
      exp = {exp_def(edge_n, 18), exp_a(edge_n, 4),
             exp_b(edge_n, 18)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL power_up(sw=%0b) edge %0d: got %h expected %h",
                 sw_dur, edge_n, act, exp);
      end
    end
  endtask

  task automatic test_async_abort();
    logic [15:0] exp;
    @(negedge clk);
    rst_async = 1'b1;
    @(negedge clk);
    rst_async = 1'b0;
    edge_n    = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = {exp_def(edge_n, 18), exp_a(edge_n, 4),
             exp_b(edge_n, 18)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL abort_pre edge %0d: got %h expected %h",
                 edge_n, act, exp);
      end
    end
    #2;
    rst_async = 1'b1;
    #1;
    n_checks++;
    if (act !== ALL_RST) begin
      n_fail++;
      $display("FAIL abort_async: got %h expected %h", act, ALL_RST);
    end
    @(negedge clk);
    rst_async = 1'b0;
    edge_n    = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp = {exp_def(edge_n, 18), exp_a(edge_n, 4),
             exp_b(edge_n, 18)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL abort_restart edge %0d: got %h expected %h",
                 edge_n, act, exp);
      end
    end
  endtask

  task automatic test_sw_from_done();
    logic [15:0] exp;
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    edge_n     = 0;
    for (int k = 0; k <= 45; k++) begin
      if (k > 0) tick();
      exp = {exp_def(edge_n, 16), exp_a(edge_n, 1),
             exp_b(edge_n, 16)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL sw_from_done R+%0d: got %h expected %h",
                 edge_n, act, exp);
      end
    end
  endtask

  task automatic test_sw_held();
    logic [15:0] exp;
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    edge_n = 0;
    for (int k = 0; k <= 50; k++) begin
      if (k > 0) tick();
      if (edge_n == 4) sw_rst_req = 1'b0;
      exp = {exp_def(edge_n, 20), exp_a(edge_n, 5),
             exp_b(edge_n, 20)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL sw_held R+%0d: got %h expected %h",
                 edge_n, act, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    test_reset();
    test_power_up(1'b0);
    test_power_up(1'b1);
    test_async_abort();
    test_sw_from_done();
    test_sw_held();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
